seq_frac_div: RTL and testbench

//  Parametrised bit-serial restoring divider producing the saturated fixed-point ratio num/den.

---
 rtl/seq_div_pkg.sv | 24 ++
 rtl/seq_div_step.sv | 23 ++
 rtl/seq_frac_div.sv | 143 ++++++++++++++
 tb/tb_seq_frac_div.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential fractional divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SAT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Largest representable quotient for a given width.
    function automatic logic [31:0] q_max(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    // Step counter must reach QUO_W (the extra guard step when rounding).
    function automatic int unsigned cnt_width(input int unsigned quo_w);
        return $clog2(quo_w + 2);
    endfunction

    localparam int unsigned SEQ_DIV_DEF_QUO_W = 8;
    localparam int unsigned SEQ_DIV_CNT_W     = $clog2(SEQ_DIV_DEF_QUO_W + 2);

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift remainder left, subtract divisor if it fits.
module seq_div_step #(
    parameter int unsigned NUM_W = 16
) (
    input  logic [NUM_W:0]   rem_i,
    input  logic [NUM_W-1:0] den_i,
    output logic [NUM_W:0]   rem_o,
    output logic             bit_o
);

    logic [NUM_W:0] shifted;
    // The remainder is always below den, so its top bit is never set.
    logic           unused_rem_msb;

    // Trial subtraction of the divisor from the doubled remainder.
    always_comb begin
        shifted        = {rem_i[NUM_W-1:0], 1'b0};
        unused_rem_msb = rem_i[NUM_W];
        bit_o          = (shifted >= {1'b0, den_i});
        rem_o          = bit_o ? (shifted - {1'b0, den_i}) : shifted;
    end

endmodule

// File: rtl/seq_frac_div.sv
// Bit-serial restoring divider: q_out = min(floor(num * 2^QUO_W / den), 2^QUO_W - 1).
// Define SEQ_FRAC_DIV_ROUND_EN to add a guard step and round to nearest (saturating).
module seq_frac_div
    import seq_div_pkg::*;
#(
    parameter int unsigned NUM_W = 16,
    parameter int unsigned QUO_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num,
    input  logic [NUM_W-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QUO_W-1:0] q_out,
    output logic             div_zero
);

    localparam int unsigned      CntW = cnt_width(QUO_W);
    localparam logic [QUO_W-1:0] QMax = QUO_W'(q_max(QUO_W));
`ifdef SEQ_FRAC_DIV_ROUND_EN
    localparam int unsigned      LastCnt = QUO_W;
`else
    localparam int unsigned      LastCnt = QUO_W - 1;
`endif

    state_t           state_q, state_d;
    logic [NUM_W:0]   rem_q, rem_d;
    logic [NUM_W-1:0] den_q, den_d;
    logic [QUO_W-1:0] quo_q, quo_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dz_pend_q, dz_pend_d;
    logic [QUO_W-1:0] q_out_q, q_out_d;
    logic             dz_q, dz_d;

    logic [NUM_W:0]   step_rem;
    logic             step_bit;
    logic [QUO_W-1:0] quo_shift;

    seq_div_step #(
        .NUM_W(NUM_W)
    ) u_step (
        .rem_i(rem_q),
        .den_i(den_q),
        .rem_o(step_rem),
        .bit_o(step_bit)
    );

`ifndef SEQ_FRAC_DIV_ROUND_EN
    // Without the guard step the oldest quotient bit is shifted straight into q_out.
    logic unused_quo_msb;
    assign unused_quo_msb = quo_q[QUO_W-1];
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q_out     = q_out_q;
    assign div_zero  = dz_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        den_d     = den_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        dz_pend_d = dz_pend_q;
        q_out_d   = q_out_q;
        dz_d      = dz_q;
        quo_shift = {quo_q[QUO_W-2:0], step_bit};
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    den_d     = den;
                    rem_d     = {1'b0, num};
                    quo_d     = '0;
                    cnt_d     = '0;
                    dz_pend_d = (den == '0);
                    // Ratio >= 1 (or undefined) saturates without iterating.
                    state_d   = ((den == '0) || (num >= den)) ? SAT : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                cnt_d = cnt_q + CntW'(1);
`ifdef SEQ_FRAC_DIV_ROUND_EN
                if (cnt_q == CntW'(LastCnt)) begin
                    // step_bit is the guard bit here; quo_q already holds the floor.
                    q_out_d = (quo_q == QMax) ? QMax : (quo_q + QUO_W'(step_bit));
                    dz_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    quo_d = quo_shift;
                end
`else
                quo_d = quo_shift;
                if (cnt_q == CntW'(LastCnt)) begin
                    q_out_d = quo_shift;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
`endif
            end
            SAT: begin
                q_out_d = QMax;
                dz_d    = dz_pend_q;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            den_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            dz_pend_q <= 1'b0;
            q_out_q   <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            den_q     <= den_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            dz_pend_q <= dz_pend_d;
            q_out_q   <= q_out_d;
            dz_q      <= dz_d;
        end
    end

endmodule

// File: tb/tb_seq_frac_div.sv
// Self-checking bench for seq_frac_div (default 16/8 instance plus a 24/12 instance).
module tb_seq_frac_div;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, div_zero;
    logic [15:0] num, den;
    logic [7:0]  q_out;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_div_zero;
    logic [23:0] w_num, w_den;
    logic [11:0] w_q_out;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seq_frac_div #(.NUM_W(16), .QUO_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
        .q_out(q_out), .div_zero(div_zero)
    );

    seq_frac_div #(.NUM_W(24), .QUO_W(12)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .num(w_num), .den(w_den), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .q_out(w_q_out), .div_zero(w_div_zero)
    );

    typedef struct {
        logic [15:0] num;
        logic [15:0] den;
        int          q;
        bit          dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: ratio from plain integer arithmetic.
    function automatic void model(input longint n, input longint d, input int qw,
                                  output longint q, output bit dz, output int lat);
        longint mx;
        longint q2;
        mx = (longint'(1) << qw) - 1;
        dz = (d == 0);
        if (d == 0 || n >= d) begin
            q   = mx;
            lat = 2;
        end else begin
`ifdef SEQ_FRAC_DIV_ROUND_EN
            q2  = (n << (qw + 1)) / d;
            q   = (q2 + 1) >> 1;
            if (q > mx) q = mx;
            lat = qw + 2;
`else
            q2  = 0;
            q   = (n << qw) / d;
            lat = qw + 1;
`endif
        end
    endfunction

    // Issue one request, scramble inputs after accept, measure latency, hand off.
    task automatic do_op(input string name, input logic [15:0] n, input logic [15:0] d,
                         input longint exp_q, input bit exp_dz, input int exp_lat);
        int lat;
        @(negedge clk);
        check({name, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        num      = n;
        den      = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num      = 16'($urandom);
        den      = 16'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".lat"}, lat, exp_lat);
        check({name, ".q"}, q_out, exp_q);
        check({name, ".dz"}, div_zero, exp_dz);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (out_valid || !in_ready || q_out != 8'(exp_q)) begin
            check({name, ".handoff"}, {out_valid, in_ready, q_out}, {1'b0, 1'b1, 8'(exp_q)});
        end else begin
            n_tests++;
        end
    endtask

    vec_t vecs[$];

    initial begin
        longint mq;
        bit     mdz;
        int     mlat;
        int     lat;
        logic [7:0] held_q;
        bit     stable;
        logic [15:0] rn, rd;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num = '0; den = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_num = '0; w_den = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.q_out", q_out, 0);
        check("reset.div_zero", div_zero, 0);

`ifdef SEQ_FRAC_DIV_ROUND_EN
        vecs.push_back('{16'd22000, 16'd22727, 248, 1'b0, 10});
        vecs.push_back('{16'd0,     16'd22727, 0,   1'b0, 10});
        vecs.push_back('{16'd100,   16'd400,   64,  1'b0, 10});
        vecs.push_back('{16'd65534, 16'd65535, 255, 1'b0, 10});
        vecs.push_back('{16'd1,     16'd65535, 0,   1'b0, 10});
        vecs.push_back('{16'd3,     16'd7,     110, 1'b0, 10});
`else
        vecs.push_back('{16'd22000, 16'd22727, 247, 1'b0, 9});
        vecs.push_back('{16'd0,     16'd22727, 0,   1'b0, 9});
        vecs.push_back('{16'd100,   16'd400,   64,  1'b0, 9});
        vecs.push_back('{16'd65534, 16'd65535, 255, 1'b0, 9});
        vecs.push_back('{16'd1,     16'd65535, 0,   1'b0, 9});
        vecs.push_back('{16'd3,     16'd7,     109, 1'b0, 9});
`endif
        vecs.push_back('{16'd22727, 16'd22727, 255, 1'b0, 2});
        vecs.push_back('{16'd500,   16'd0,     255, 1'b1, 2});
        vecs.push_back('{16'd100,   16'd400,   64,  1'b0, vecs[2].lat});
        vecs.push_back('{16'd65535, 16'd1,     255, 1'b0, 2});
        vecs.push_back('{16'd0,     16'd0,     255, 1'b1, 2});

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].num, vecs[i].den,
                  vecs[i].q, vecs[i].dz, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            rd = 16'($urandom_range(0, 65535));
            if (i % 8 == 0) rd = 16'($urandom_range(0, 3));
            rn = (i % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, int'(rd)));
            model(longint'(rn), longint'(rd), 8, mq, mdz, mlat);
            do_op($sformatf("rand%0d", i), rn, rd, mq, mdz, mlat);
        end

        // Backpressure: result must hold and new requests must be ignored.
        @(negedge clk);
        in_valid = 1'b1; num = 16'd22000; den = 16'd22727;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall.valid", out_valid, 1);
        held_q = q_out;
        model(22000, 22727, 8, mq, mdz, mlat);
        check("stall.q", held_q, mq);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = c[0];
            num = 16'd1; den = 16'd0;
            @(posedge clk);
            #1;
            if (!out_valid || q_out != held_q || in_ready || div_zero) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("stall.stable", stable, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall.release", {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        #1;
        check("stall.no_queue", {out_valid, in_ready}, 2'b01);

        // Reset in the middle of an iteration.
        @(negedge clk);
        in_valid = 1'b1; num = 16'd3; den = 16'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst.state", {out_valid, in_ready, div_zero}, 3'b010);
        check("midrst.q", q_out, 0);
        repeat (12) @(posedge clk);
        #1;
        check("midrst.no_result", out_valid, 0);
        model(100, 400, 8, mq, mdz, mlat);
        do_op("after_rst", 16'd100, 16'd400, mq, mdz, mlat);

        // Wide configuration: 1/2 at 12 fractional bits.
        @(negedge clk);
        w_in_valid = 1'b1; w_num = 24'd1; w_den = 24'd2;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        w_num = '0; w_den = '0;
        lat = 1;
        while (!w_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        model(1, 2, 12, mq, mdz, mlat);
        check("wide.lat", lat, mlat);
        check("wide.q", w_q_out, mq);
        check("wide.dz", w_div_zero, 0);
        @(negedge clk);
        w_out_ready = 1'b1;
        @(posedge clk);
        #1;
        w_out_ready = 1'b0;
        check("wide.handoff", {w_out_valid, w_in_ready}, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
